// File: rtl/cbadc_chain_modulator_fxp.sv
// Chain-of-integrators control-bounded ADC modulator: one N-bit control vector per enabled clock.
// Latency: u reaches x_0/out in one enabled step; no backpressure, en=0 freezes all state.
module cbadc_chain_modulator_fxp #(
   parameter int N      = 3,
   parameter int n_int  = 3,
   parameter int n_mant = 8,
   parameter int B      = 2,
   parameter int WARMUP = 16
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                en,
   input  logic signed [n_mant:0]              u,
   output logic        [N-1:0]                 out,
   output logic                                valid,
   output logic                                ovf,
   output logic        [N*(n_int+n_mant+1)-1:0] state
);
   localparam int W  = n_int + n_mant + 1;
   localparam int SW = W + 2;
   localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
   localparam logic signed [SW-1:0] F_POS = SW'((1 << n_mant) >>> B);
   localparam logic signed [SW-1:0] X_MAX = SW'((1 << (W - 1)) - 1);
   localparam logic signed [SW-1:0] X_MIN = -X_MAX - SW'(1);

   logic signed [W-1:0]  x_q [N];
   logic signed [W-1:0]  x_d [N];
   logic        [N-1:0]  out_q, out_d;
   logic                 valid_q, valid_d;
   logic                 ovf_q, ovf_d;
   logic        [CW-1:0] cnt_q, cnt_d;

   logic signed [W-1:0]  src  [N];
   logic signed [SW-1:0] sum  [N];
   logic signed [SW-1:0] satv [N];
   logic        [N-1:0]  clamp;

   always_comb begin
      x_d   = x_q;
      out_d = out_q;
      clamp = '0;
      // Stage 0 integrates the input sample; every stage reads pre-edge neighbours (Jacobi update).
      src[0] = W'(u);
      for (int k = 1; k < N; k++) begin
         src[k] = x_q[k-1];
      end
      for (int k = 0; k < N; k++) begin
         sum[k] = SW'(x_q[k]) + SW'(src[k] >>> B) + (out_q[k] ? -F_POS : F_POS);
         satv[k] = sum[k];
         if (sum[k] > X_MAX) begin
            satv[k]  = X_MAX;
            clamp[k] = 1'b1;
         end else if (sum[k] < X_MIN) begin
            satv[k]  = X_MIN;
            clamp[k] = 1'b1;
         end
         if (en) begin
            x_d[k]   = satv[k][W-1:0];
            out_d[k] = ~satv[k][W-1];
         end
      end
      ovf_d = ovf_q | (en & (|clamp));

      cnt_d = cnt_q;
      if (en && (cnt_q != CW'(WARMUP))) begin
         cnt_d = cnt_q + CW'(1);
      end
      // With WARMUP=0 the counter already sits at its target, so valid rises on the first edge.
      valid_d = valid_q | (cnt_d == CW'(WARMUP));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            x_q[k] <= '0;
         end
         out_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            x_q[k] <= x_d[k];
         end
         out_q   <= out_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out   = out_q;
   assign valid = valid_q;
   assign ovf   = ovf_q;

   for (genvar k = 0; k < N; k++) begin : g_state
      assign state[k*W +: W] = x_q[k];
   end

endmodule

// File: tb/tb_cbadc_chain_modulator_fxp.sv
// Bench for cbadc_chain_modulator_fxp: directed test-plan vectors plus randomized runs
// against an integer-arithmetic model of the integrator chain.
module tb_cbadc_chain_modulator_fxp;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              en  = 1'b0;
   logic signed [8:0] u   = '0;

   logic [2:0]  out_a, out_w, out_s;
   logic        valid_a, valid_w, valid_s;
   logic        ovf_a, ovf_w, ovf_s;
   logic [35:0] state_a, state_w;
   logic [26:0] state_s;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cbadc_chain_modulator_fxp #(.N(3), .n_int(3), .n_mant(8), .B(2), .WARMUP(16)) dut_a (
      .clk(clk), .rst(rst), .en(en), .u(u),
      .out(out_a), .valid(valid_a), .ovf(ovf_a), .state(state_a));

   cbadc_chain_modulator_fxp #(.N(3), .n_int(3), .n_mant(8), .B(2), .WARMUP(0)) dut_w (
      .clk(clk), .rst(rst), .en(en), .u(u),
      .out(out_w), .valid(valid_w), .ovf(ovf_w), .state(state_w));

   cbadc_chain_modulator_fxp #(.N(3), .n_int(0), .n_mant(8), .B(0), .WARMUP(16)) dut_s (
      .clk(clk), .rst(rst), .en(en), .u(u),
      .out(out_s), .valid(valid_s), .ovf(ovf_s), .state(state_s));

   // ---------------- reference model ----------------
   int       m_x [3];
   bit [2:0] m_out;
   bit       m_ovf, m_valid;
   int       m_cnt;
   int       p_nint = 3, p_b = 2, p_warm = 16;

   int exp_x [3][3] = '{'{64, 64, 64}, '{0, 16, 16}, '{-64, -48, -44}};
   bit [2:0] exp_o [3] = '{3'b111, 3'b111, 3'b000};

   function automatic int floor_div(int a, int d);
      if (a >= 0) return a / d;
      return -((-a + d - 1) / d);
   endfunction

   function automatic int fld(logic [63:0] st, int w, int k);
      logic [63:0] t;
      int v;
      t = st >> (k * w);
      v = int'(t & ((64'd1 << w) - 64'd1));
      if (t[w-1]) v = v - (1 << w);
      return v;
   endfunction

   function automatic logic [63:0] pack_model(int w);
      logic [63:0] r = '0;
      for (int k = 0; k < 3; k++)
         r = r | ((64'(m_x[k]) & ((64'd1 << w) - 64'd1)) << (k * w));
      return r;
   endfunction

   task automatic set_cfg(int nint, int b, int warm);
      p_nint = nint; p_b = b; p_warm = warm;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) m_x[k] = 0;
      m_out = '0; m_ovf = 0; m_valid = 0; m_cnt = 0;
   endtask

   task automatic model_step(bit e, int uin);
      int nx [3];
      int w, lo, hi, f, src, s;
      if (e) begin
         w  = p_nint + 9;
         hi = (1 << (w - 1)) - 1;
         lo = -(1 << (w - 1));
         f  = 256 / (1 << p_b);
         for (int k = 0; k < 3; k++) begin
            src = (k == 0) ? uin : m_x[k-1];
            s   = m_x[k] + floor_div(src, 1 << p_b) + (m_out[k] ? -f : f);
            if (s > hi) begin nx[k] = hi; m_ovf = 1; end
            else if (s < lo) begin nx[k] = lo; m_ovf = 1; end
            else nx[k] = s;
         end
         for (int k = 0; k < 3; k++) begin
            m_x[k]   = nx[k];
            m_out[k] = (nx[k] >= 0);
         end
         if (m_cnt < p_warm) m_cnt++;
      end
      if (m_cnt >= p_warm) m_valid = 1;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(bit e, int uv);
      en = e;
      u  = 9'(uv);
      model_step(e, uv);
      tick();
   endtask

   task automatic apply_reset();
      rst = 1'b0; en = 1'b0; u = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      #3;
      n_checks++;
      if ({state_a, out_a, valid_a, ovf_a} !== '0) begin
         n_fail++; $display("FAIL reset_a: got state=%h out=%b valid=%b ovf=%b, want all 0", state_a, out_a, valid_a, ovf_a);
      end
      n_checks++;
      if ({state_w, out_w, valid_w, ovf_w} !== '0) begin
         n_fail++; $display("FAIL reset_w: got state=%h out=%b valid=%b ovf=%b, want all 0", state_w, out_w, valid_w, ovf_w);
      end
      n_checks++;
      if ({state_s, out_s, valid_s, ovf_s} !== '0) begin
         n_fail++; $display("FAIL reset_s: got state=%h out=%b valid=%b ovf=%b, want all 0", state_s, out_s, valid_s, ovf_s);
      end
   endtask

   task automatic test_directed();
      set_cfg(3, 2, 16);
      apply_reset();
      for (int s = 0; s < 3; s++) begin
         drive(1'b1, 0);
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (fld(64'(state_a), 12, k) != exp_x[s][k]) begin
               n_fail++; $display("FAIL directed_x step%0d k%0d: got %0d want %0d", s + 1, k, fld(64'(state_a), 12, k), exp_x[s][k]);
            end
         end
         n_checks++;
         if (out_a !== exp_o[s] || ovf_a !== 1'b0) begin
            n_fail++; $display("FAIL directed_out step%0d: got out=%b ovf=%b want out=%b ovf=0", s + 1, out_a, ovf_a, exp_o[s]);
         end
      end
   endtask

   task automatic test_en_toggle();
      set_cfg(3, 2, 16);
      apply_reset();
      drive(1'b1, 0);
      repeat (5) begin
         drive(1'b0, 0);
         n_checks++;
         if (fld(64'(state_a), 12, 0) != 64 || fld(64'(state_a), 12, 1) != 64 ||
             fld(64'(state_a), 12, 2) != 64 || out_a !== 3'b111) begin
            n_fail++; $display("FAIL en_hold: got state=%h out=%b want x=(64,64,64) out=111", state_a, out_a);
         end
      end
      for (int s = 1; s < 3; s++) begin
         drive(1'b1, 0);
         n_checks++;
         if (fld(64'(state_a), 12, 0) != exp_x[s][0] || fld(64'(state_a), 12, 1) != exp_x[s][1] ||
             fld(64'(state_a), 12, 2) != exp_x[s][2] || out_a !== exp_o[s]) begin
            n_fail++; $display("FAIL en_resume step%0d: got state=%h out=%b want x=(%0d,%0d,%0d) out=%b",
                               s + 1, state_a, out_a, exp_x[s][0], exp_x[s][1], exp_x[s][2], exp_o[s]);
         end
      end
   endtask

   task automatic test_warmup();
      int ecount = 0;
      bit e;
      set_cfg(3, 2, 16);
      apply_reset();
      n_checks++;
      if (valid_w !== 1'b0) begin
         n_fail++; $display("FAIL warmup0_pre: got valid=%b want 0", valid_w);
      end
      drive(1'b0, 0);
      n_checks++;
      if (valid_w !== 1'b1 || valid_a !== 1'b0) begin
         n_fail++; $display("FAIL warmup0_first_edge: got valid_w=%b valid_a=%b want 1 and 0", valid_w, valid_a);
      end
      for (int i = 0; i < 60; i++) begin
         e = (i % 3 == 0);
         drive(e, int'($urandom_range(0, 511)) - 256);
         if (e) ecount++;
         n_checks++;
         if (valid_a !== (ecount >= 16)) begin
            n_fail++; $display("FAIL warmup16 cycle%0d enabled=%0d: got valid=%b want %b", i, ecount, valid_a, ecount >= 16);
         end
      end
   endtask

   task automatic test_saturation();
      set_cfg(0, 0, 16);
      apply_reset();
      drive(1'b1, 255);
      n_checks++;
      if (fld(64'(state_s), 9, 0) != 255 || ovf_s !== 1'b1) begin
         n_fail++; $display("FAIL sat_first: got x0=%0d ovf=%b want 255 and 1", fld(64'(state_s), 9, 0), ovf_s);
      end
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, (i < 20) ? 255 : 0);
         n_checks++;
         if (64'(state_s) !== pack_model(9) || out_s !== m_out || ovf_s !== m_ovf || ovf_s !== 1'b1) begin
            n_fail++; $display("FAIL sat_run step%0d: got state=%h out=%b ovf=%b want state=%h out=%b ovf=1",
                               i, state_s, out_s, ovf_s, pack_model(9), m_out);
         end
      end
   endtask

   task automatic test_async_reset();
      set_cfg(3, 2, 16);
      apply_reset();
      repeat (4) drive(1'b1, 0);
      en = 1'b1; u = '0;
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({state_a, out_a, valid_a, ovf_a} !== '0) begin
         n_fail++; $display("FAIL async_reset: got state=%h out=%b valid=%b ovf=%b want all 0", state_a, out_a, valid_a, ovf_a);
      end
      #7;
      tick();
      rst = 1'b1;
      model_reset();
      for (int s = 0; s < 3; s++) begin
         drive(1'b1, 0);
         n_checks++;
         if (fld(64'(state_a), 12, 0) != exp_x[s][0] || fld(64'(state_a), 12, 1) != exp_x[s][1] ||
             fld(64'(state_a), 12, 2) != exp_x[s][2] || out_a !== exp_o[s]) begin
            n_fail++; $display("FAIL async_restart step%0d: got state=%h out=%b want x=(%0d,%0d,%0d) out=%b",
                               s + 1, state_a, out_a, exp_x[s][0], exp_x[s][1], exp_x[s][2], exp_o[s]);
         end
      end
   endtask

   task automatic test_random();
      set_cfg(3, 2, 16);
      apply_reset();
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 511)) - 256);
         n_checks++;
         if (64'(state_a) !== pack_model(12) || out_a !== m_out || valid_a !== m_valid || ovf_a !== m_ovf) begin
            n_fail++; $display("FAIL random step%0d: got state=%h out=%b valid=%b ovf=%b want state=%h out=%b valid=%b ovf=%b",
                               i, state_a, out_a, valid_a, ovf_a, pack_model(12), m_out, m_valid, m_ovf);
         end
      end
   endtask

   task automatic test_loopback();
      int run [3];
      int maxrun [3];
      bit [2:0] prev;
      set_cfg(3, 2, 16);
      apply_reset();
      for (int k = 0; k < 3; k++) begin run[k] = 0; maxrun[k] = 0; end
      prev = '0;
      for (int i = 0; i < 200; i++) begin
         drive(1'b1, ((i / 16) % 2 == 0) ? 128 : -128);
         for (int k = 0; k < 3; k++) begin
            run[k] = (i > 0 && out_a[k] == prev[k]) ? run[k] + 1 : 1;
            if (run[k] > maxrun[k]) maxrun[k] = run[k];
         end
         prev = out_a;
         n_checks++;
         if (64'(state_a) !== pack_model(12) || out_a !== m_out) begin
            n_fail++; $display("FAIL loopback step%0d: got state=%h out=%b want state=%h out=%b",
                               i, state_a, out_a, pack_model(12), m_out);
         end
      end
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (maxrun[k] > 32) begin
            n_fail++; $display("FAIL loopback_run bit%0d: got longest run %0d want <= 32", k, maxrun[k]);
         end
      end
      n_checks++;
      if (ovf_a !== 1'b0) begin
         n_fail++; $display("FAIL loopback_ovf: got %b want 0", ovf_a);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_en_toggle();
      test_warmup();
      test_saturation();
      test_async_reset();
      test_random();
      test_loopback();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cbadc_chain_modulator_fxp.md
Name: cbadc_chain_modulator_fxp

Overview:
- Fixed-point, cycle-accurate digital model of a chain-of-integrators control-bounded ADC front end.
- Generates the N-bit control-signal stream that the control-bounded estimation filters consume on their `in` port. It is the transmitting end of that interface.
- Used as the stimulus source in filter benches and in FPGA loopback builds, with a synthesized test tone or external samples on `u`.
- One control vector is emitted per enabled clock.

Parameters:
- N, 3, number of integrator stages and width of the control vector.
- n_int, 3, integer bits of each integrator state (excluding sign).
- n_mant, 8, fractional bits. Unit value 1.0 = 1 <<< n_mant.
- B, 2, beta shift. Integrator gain beta = 2^-B.
- WARMUP, 16, number of enabled steps before `valid` asserts.

Ports:
- clk  in  1  system clock, posedge.
- rst  in  1  asynchronous active-low reset.
- en  in  1  step enable. One integration step per clk with en=1.
- u  in  n_mant+1  signed input sample, fraction format (0 integer bits), sampled when en=1.
- out  out  N  control vector. Bit k = s_k.
- valid  out  1  asserted once WARMUP steps have completed since reset.
- ovf  out  1  sticky saturation flag.
- state  out  N*(n_int+n_mant+1)  integrator states. x_k is at [k*W +: W] with W = n_int+n_mant+1. Verification visibility only.

Behaviour:
- Reset (rst=0, asynchronous), required values:
  - all x_k = 0, out = '0, valid = 0, ovf = 0, warmup counter = 0.
  - Reset asserted mid-run clears everything on the spot. The first enabled step after release behaves exactly like a step from power-up.
- Notation:
  - unit = 1 <<< n_mant.
  - f = unit >>> B.
  - x_{-1} = u sign-extended and aligned to the W-bit state format.
- Feedback term fb_k = +f when s_k = 0, and -f when s_k = 1.
- Step update, on a clk edge with en=1 and rst=1. All stages update simultaneously from the pre-edge values (Jacobi order, not sequential):
  - x_k' = sat( x_k + (x_{k-1} >>> B) + fb_k ), for k = 0..N-1.
  - `>>>` is arithmetic and truncates toward minus infinity.
  - The sum is computed at W+2 bits.
  - sat clamps to [-2^(W-1), 2^(W-1)-1]. Any clamp sets ovf=1, which stays set until reset.
- Control update, same edge: out[k] = (x_k' >= 0). Out therefore reflects the state just written; latency from u to x_0 is 1 step.
- en=0: x, out, valid and ovf hold, and the counter does not advance.
- Warmup:
  - The counter increments per enabled step and saturates at WARMUP.
  - valid = 1 from the edge on which the counter reaches WARMUP. It stays 1 until reset.
  - WARMUP=0 means valid rises on the first edge after reset release.
- The `state` output is a direct copy of the registers, with no extra latency.
- No combinational path from u or en to any output. All outputs are registered.
- No internal derived clocks. Downsampling is left to the consumer.

Test Plan:
- Defaults, u=0, en=1 for 3 steps after reset:
  - step 1 → x=(64,64,64), out=3'b111.
  - step 2 → x=(0,16,16), out=3'b111.
  - step 3 → x=(-64,-48,-44), out=3'b000.
  - ovf=0 throughout.
- en toggling: same stimulus with en=0 inserted between steps 1 and 2 for 5 clocks → x, out and state frozen at step-1 values. The sequence then resumes identically.
- Warmup: WARMUP=16, en=1 with a 1-in-3 duty → valid rises exactly on the 16th enabled edge and stays high. With WARMUP=0, valid rises on the first edge.
- Saturation: n_int=0, u=+255 held, out forced by long run → x_0 clamps at 255 (max). ovf sets on the first clamp and remains 1 after u returns to 0.
- Async reset mid-run: assert rst=0 between clock edges during step 5 → all outputs zero immediately, with no clk edge needed. After release, the first 3 steps repeat the values from the first scenario.
- Consumer loopback: u = ±0.5 square wave (±128), 200 steps → out never holds one value for more than 32 consecutive steps per bit, and ovf=0 (bounded operation).
